// File: rtl/zet_int_ctrl_pkg.sv
// rtl/zet_int_ctrl_pkg.sv - shared constants and helpers for the interrupt controller
package zet_int_ctrl_pkg;

  // Register select values on io_addr
  localparam logic [1:0] ADDR_IRR   = 2'd0;  // W: command (EOI), R: IRR
  localparam logic [1:0] ADDR_IMR   = 2'd1;
  localparam logic [1:0] ADDR_VBASE = 2'd2;
  localparam logic [1:0] ADDR_ISR   = 2'd3;

  // Command bit in a register-0 write that requests a non-specific EOI
  localparam int EOI_BIT = 5;

  // Low vector bits returned when an acknowledge finds nothing to grant
  localparam logic [2:0] SPUR_LO = 3'd7;

  // Index of the lowest set bit (highest priority); 8 when no bit is set
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zet_int_edge.sv
// rtl/zet_int_edge.sv - pin synchroniser with rising-edge pulse output
module zet_int_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async pin through the synchroniser and remember the last synced level.
  // Both clear to 0 so a pin already high at reset exit is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/zet_int_ctrl.sv
// rtl/zet_int_ctrl.sv - 8-input fixed-priority interrupt controller plus NMI request
module zet_int_ctrl
  import zet_int_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IMR_RST     = 8'hFF,
  parameter logic [7:0] VBASE_RST   = 8'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_irq,
  input  logic       i_nmi_pin,
  output logic       o_intr,
  input  logic       i_inta,
  output logic       o_nmir,
  input  logic       i_nmia,
  output logic [7:0] o_iv,
  input  logic       i_io_wr,
  input  logic       i_io_rd,
  input  logic [1:0] i_io_addr,
  input  logic [7:0] i_io_dat_i,
  output logic [7:0] o_io_dat_o
);

  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic [4:0] r_vbase;
  logic       r_intr;
  logic       r_nmir;
  logic [7:0] r_iv;
  logic [7:0] r_dat_o;

  logic [7:0] w_irq_rise;
  logic       w_nmi_rise;
  logic [7:0] w_pend;
  logic [3:0] w_p;
  logic [3:0] w_s;
  logic       w_req;
  logic       w_grant;
  logic       w_eoi;
  logic [7:0] w_irr_nxt;
  logic [7:0] w_isr_nxt;

  for (genvar g = 0; g < 8; g++) begin : g_irq_edge
    zet_int_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clk    (clk),
      .rst    (rst),
      .i_pin  (i_irq[g]),
      .o_rise (w_irq_rise[g])
    );
  end

  zet_int_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_edge (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (i_nmi_pin),
    .o_rise (w_nmi_rise)
  );

  // A request is only raised when the best unmasked pending line outranks everything in service
  assign w_pend  = r_irr & ~r_imr;
  assign w_p     = lowest_set(w_pend);
  assign w_s     = lowest_set(r_isr);
  assign w_req   = (|w_pend) && (w_p < w_s);
  assign w_grant = i_inta && w_req;
  assign w_eoi   = i_io_wr && (i_io_addr == ADDR_IRR) && i_io_dat_i[EOI_BIT];

  // Next IRR/ISR: grant clears before new edges set (edge wins); EOI clears before grant sets
  always_comb begin
    w_irr_nxt = r_irr;
    w_isr_nxt = r_isr;
    if (w_grant) w_irr_nxt[w_p[2:0]] = 1'b0;
    w_irr_nxt = w_irr_nxt | w_irq_rise;
    if (w_eoi && !w_s[3]) w_isr_nxt[w_s[2:0]] = 1'b0;
    if (w_grant) w_isr_nxt[w_p[2:0]] = 1'b1;
  end

  // Pending/in-service state, handshake outputs and vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irr  <= 8'h00;
      r_isr  <= 8'h00;
      r_intr <= 1'b0;
      r_nmir <= 1'b0;
      r_iv   <= 8'h00;
    end else begin
      r_irr  <= w_irr_nxt;
      r_isr  <= w_isr_nxt;
      r_intr <= i_inta ? 1'b0 : w_req;
      if (w_nmi_rise)  r_nmir <= 1'b1;
      else if (i_nmia) r_nmir <= 1'b0;
      if (i_inta) r_iv <= w_req ? {r_vbase, w_p[2:0]} : {r_vbase, SPUR_LO};
    end
  end

  // Writable configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imr   <= IMR_RST;
      r_vbase <= VBASE_RST[7:3];
    end else if (i_io_wr) begin
      if (i_io_addr == ADDR_IMR)   r_imr   <= i_io_dat_i;
      if (i_io_addr == ADDR_VBASE) r_vbase <= i_io_dat_i[7:3];
    end
  end

  // Registered read port, holds its value between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat_o <= 8'h00;
    end else if (i_io_rd) begin
      case (i_io_addr)
        ADDR_IRR:   r_dat_o <= r_irr;
        ADDR_IMR:   r_dat_o <= r_imr;
        ADDR_VBASE: r_dat_o <= {r_vbase, 3'b000};
        ADDR_ISR:   r_dat_o <= r_isr;
        default:    r_dat_o <= 8'h00;
      endcase
    end
  end

  assign o_intr     = r_intr;
  assign o_nmir     = r_nmir;
  assign o_iv       = r_iv;
  assign o_io_dat_o = r_dat_o;

endmodule

// File: tb/tb_zet_int_ctrl.sv
// tb/tb_zet_int_ctrl.sv - directed self-checking bench for zet_int_ctrl
module tb_zet_int_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       nmi_pin;
  logic       intr;
  logic       inta;
  logic       nmir;
  logic       nmia;
  logic [7:0] iv;
  logic       io_wr;
  logic       io_rd;
  logic [1:0] io_addr;
  logic [7:0] io_dat_i;
  logic [7:0] io_dat_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] rd_val;

  zet_int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_irq      (irq),
    .i_nmi_pin  (nmi_pin),
    .o_intr     (intr),
    .i_inta     (inta),
    .o_nmir     (nmir),
    .i_nmia     (nmia),
    .o_iv       (iv),
    .i_io_wr    (io_wr),
    .i_io_rd    (io_rd),
    .i_io_addr  (io_addr),
    .i_io_dat_i (io_dat_i),
    .o_io_dat_o (io_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder never acknowledges both request types at once
  always @(posedge clk) begin
    if (inta && nmia) begin
      n_total++;
      $error("FAIL inta_nmia_overlap observed=1 expected=0");
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_wr = 1'b1; io_addr = a; io_dat_i = d;
    tick(1);
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    io_rd = 1'b1; io_addr = a;
    tick(1);
    io_rd = 1'b0;
    d = io_dat_o;
  endtask

  task automatic ack();
    inta = 1'b1;
    tick(1);
    inta = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick(1);
    irq = 8'h00;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; nmi_pin = 1'b0; inta = 1'b0; nmia = 1'b0;
    io_wr = 1'b0; io_rd = 1'b0; io_addr = 2'd0; io_dat_i = 8'h00;
    tick(2);
    chk("rst_intr", {7'd0, intr}, 8'h00);
    chk("rst_nmir", {7'd0, nmir}, 8'h00);
    chk("rst_iv", iv, 8'h00);
    chk("rst_dat_o", io_dat_o, 8'h00);
    rst = 1'b0;
    rd(2'd1, rd_val); chk("rst_imr", rd_val, 8'hFF);
    rd(2'd2, rd_val); chk("rst_vbase", rd_val, 8'h08);
    rd(2'd0, rd_val); chk("rst_irr", rd_val, 8'h00);

    // irq2 alone, others masked: intr on the 4th edge after the pin rises
    wr(2'd1, 8'hFB);
    pulse_irq(8'h04);
    tick(2);
    chk("irq2_intr_edge3", {7'd0, intr}, 8'h00);
    tick(1);
    chk("irq2_intr_edge4", {7'd0, intr}, 8'h01);
    ack();
    chk("irq2_iv", iv, 8'h0A);
    chk("irq2_intr_after_ack", {7'd0, intr}, 8'h00);
    rd(2'd3, rd_val); chk("irq2_isr", rd_val, 8'h04);
    rd(2'd0, rd_val); chk("irq2_irr", rd_val, 8'h00);
    wr(2'd0, 8'h20);
    rd(2'd3, rd_val); chk("irq2_isr_eoi", rd_val, 8'h00);

    // irq3 and irq1 together: irq1 first, irq3 held off until EOI
    wr(2'd1, 8'h00);
    pulse_irq(8'h0A);
    tick(3);
    chk("pair_intr", {7'd0, intr}, 8'h01);
    ack();
    chk("pair_iv1", iv, 8'h09);
    tick(2);
    chk("pair_blocked", {7'd0, intr}, 8'h00);
    wr(2'd0, 8'h20);
    tick(1);
    chk("pair_intr_after_eoi", {7'd0, intr}, 8'h01);
    ack();
    chk("pair_iv3", iv, 8'h0B);
    wr(2'd0, 8'h20);
    rd(2'd3, rd_val); chk("pair_isr_clear", rd_val, 8'h00);

    // Nesting: irq0 preempts in-service irq1, irq4 does not
    pulse_irq(8'h02);
    tick(3);
    ack();
    chk("nest_iv1", iv, 8'h09);
    pulse_irq(8'h01);
    tick(3);
    chk("nest_intr_irq0", {7'd0, intr}, 8'h01);
    ack();
    chk("nest_iv0", iv, 8'h08);
    wr(2'd0, 8'h20);
    rd(2'd3, rd_val); chk("nest_isr_after_eoi", rd_val, 8'h02);
    pulse_irq(8'h10);
    tick(4);
    chk("nest_irq4_blocked", {7'd0, intr}, 8'h00);
    rd(2'd0, rd_val); chk("nest_irr4", rd_val, 8'h10);
    wr(2'd0, 8'h20);
    tick(1);
    chk("nest_irq4_intr", {7'd0, intr}, 8'h01);
    ack();
    chk("nest_iv4", iv, 8'h0C);
    wr(2'd0, 8'h20);

    // Spurious acknowledge with nothing pending
    wr(2'd2, 8'h77);
    rd(2'd2, rd_val); chk("vbase_low_ignored", rd_val, 8'h70);
    ack();
    chk("spur_iv", iv, 8'h77);
    rd(2'd3, rd_val); chk("spur_isr", rd_val, 8'h00);

    // NMI ignores mask; a new edge beats a same-cycle nmia
    wr(2'd1, 8'hFF);
    nmi_pin = 1'b1; tick(1); nmi_pin = 1'b0;
    tick(1);
    chk("nmi_edge2", {7'd0, nmir}, 8'h00);
    tick(1);
    chk("nmi_set", {7'd0, nmir}, 8'h01);
    nmi_pin = 1'b1; tick(1); nmi_pin = 1'b0;
    tick(1);
    nmia = 1'b1; tick(1); nmia = 1'b0;
    chk("nmi_edge_wins", {7'd0, nmir}, 8'h01);
    nmia = 1'b1; tick(1); nmia = 1'b0;
    chk("nmi_cleared", {7'd0, nmir}, 8'h00);

    // irq5 held high across a reset: one fresh edge after reset, then none
    wr(2'd1, 8'h00);
    irq = 8'h20;
    tick(4);
    chk("held_intr", {7'd0, intr}, 8'h01);
    rst = 1'b1;
    tick(1);
    chk("held_rst_intr", {7'd0, intr}, 8'h00);
    rst = 1'b0;
    rd(2'd0, rd_val); chk("held_irr_after_rst", rd_val, 8'h00);
    rd(2'd1, rd_val); chk("held_imr_after_rst", rd_val, 8'hFF);
    tick(1);
    rd(2'd0, rd_val); chk("held_relatch", rd_val, 8'h20);
    wr(2'd1, 8'hDF);
    tick(1);
    chk("held_intr_unmask", {7'd0, intr}, 8'h01);
    ack();
    chk("held_iv", iv, 8'h0D);
    tick(10);
    rd(2'd0, rd_val); chk("held_no_relatch", rd_val, 8'h00);
    irq = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
